// File: rtl/fix_conn_manager.sv
// Connection scheduler serializing up to 4 host sessions onto a single TOE connect/disconnect channel.
// Optional FIX_CONN_STATS_EN adds saturating fail/retry counters.
module fix_conn_manager #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic [3:0] disc_i,
  input  logic       connected_i,
  input  logic [1:0] connected_host_addr_i,
  output logic       connect_req_o,
  output logic [1:0] connect_addr_o,
  output logic       disconnect_o,
  output logic [1:0] disconnect_host_num_o,
  output logic [3:0] session_up_o,
  output logic [3:0] done_o,
  output logic [3:0] fail_o,
  output logic       busy_o
`ifdef FIX_CONN_STATS_EN
  ,
  output logic [7:0] fail_count_o,
  output logic [7:0] retry_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONNECT,
    S_WAIT,
    S_DISC
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_conn_pend;
  logic [3:0]       r_disc_pend;
  logic [3:0]       r_session_up;
  logic [3:0]       r_done;
  logic [3:0]       r_fail;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_target;
  logic [1:0]       r_disc_host;
  logic [3:0]       r_retry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_tgt_busy;
  logic [3:0]       w_tgt_mask;
  logic [3:0]       w_disc_mask;
  logic             w_succ;
  logic             w_tmo;
  logic             w_retry_ok;
  logic             w_give_up;
  logic [3:0]       w_conn_set;
  logic [3:0]       w_disc_set;
  logic [3:0]       w_conn_clr;
  logic [3:0]       w_disc_clr;
  logic             w_disc_any;
  logic [1:0]       w_disc_sel;
  logic             w_conn_any;
  logic [1:0]       w_conn_sel;
  logic [1:0]       w_idx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_tgt_busy  = (r_state == S_CONNECT) || (r_state == S_WAIT);
  assign w_tgt_mask  = 4'b0001 << r_target;
  assign w_disc_mask = 4'b0001 << r_disc_host;

  // A matching ack beats a simultaneous timeout; acks for other hosts are ignored.
  assign w_succ     = (r_state == S_WAIT) && connected_i && (connected_host_addr_i == r_target);
  assign w_tmo      = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_succ;
  assign w_retry_ok = (r_retry < 4'(MAX_RETRIES));
  assign w_give_up  = w_tmo && !w_retry_ok;

  // Disconnect wins over a same-cycle connect request for the same host.
  assign w_conn_set = req_i & ~disc_i & ~r_session_up & ~(w_tgt_busy ? w_tgt_mask : 4'b0000);
  assign w_disc_set = disc_i & r_session_up;
  assign w_conn_clr = (w_succ || w_give_up) ? w_tgt_mask : 4'b0000;
  assign w_disc_clr = (r_state == S_DISC) ? w_disc_mask : 4'b0000;
  assign w_disc_any = |r_disc_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_conn_any  = 1'b0;
    w_conn_sel  = r_rr_ptr;
    w_idx       = 2'd0;
    w_disc_sel  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_disc_pend[i]) w_disc_sel = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_conn_any && r_conn_pend[w_idx]) begin
        w_conn_sel = w_idx;
        w_conn_any = 1'b1;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_disc_any)      w_state_nxt = S_DISC;
        else if (w_conn_any) w_state_nxt = S_CONNECT;
      end
      S_CONNECT: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_succ)     w_state_nxt = S_IDLE;
        else if (w_tmo) w_state_nxt = w_retry_ok ? S_CONNECT : S_IDLE;
      end
      S_DISC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conn_pend  <= 4'b0000;
      r_disc_pend  <= 4'b0000;
      r_session_up <= 4'b0000;
      r_done       <= 4'b0000;
      r_fail       <= 4'b0000;
      r_rr_ptr     <= 2'd0;
      r_target     <= 2'd0;
      r_disc_host  <= 2'd0;
      r_retry      <= 4'd0;
      r_cnt        <= '0;
    end else begin
      r_done      <= 4'b0000;
      r_fail      <= 4'b0000;
      r_conn_pend <= (r_conn_pend | w_conn_set) & ~w_conn_clr;
      r_disc_pend <= (r_disc_pend | w_disc_set) & ~w_disc_clr;
      case (r_state)
        S_IDLE: begin
          if (w_disc_any) begin
            r_disc_host <= w_disc_sel;
          end else if (w_conn_any) begin
            r_target <= w_conn_sel;
            r_retry  <= 4'd0;
          end
        end
        S_CONNECT: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_succ) begin
            r_session_up <= r_session_up | w_tgt_mask;
            r_done       <= w_tgt_mask;
            r_rr_ptr     <= r_target + 2'd1;
          end else if (w_tmo) begin
            if (w_retry_ok) begin
              r_retry <= r_retry + 4'd1;
            end else begin
              r_fail   <= w_tgt_mask;
              r_rr_ptr <= r_target + 2'd1;
            end
          end
        end
        S_DISC:  r_session_up <= r_session_up & ~w_disc_mask;
        default: ;
      endcase
    end
  end

`ifdef FIX_CONN_STATS_EN
  logic [7:0] r_fail_cnt;
  logic [7:0] r_retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_cnt  <= 8'd0;
      r_retry_cnt <= 8'd0;
    end else begin
      if (w_give_up)            r_fail_cnt  <= sat_inc8(r_fail_cnt);
      if (w_tmo && w_retry_ok)  r_retry_cnt <= sat_inc8(r_retry_cnt);
    end
  end

  assign fail_count_o  = r_fail_cnt;
  assign retry_count_o = r_retry_cnt;
`endif

  assign connect_req_o         = (r_state == S_CONNECT);
  assign connect_addr_o        = r_target;
  assign disconnect_o          = (r_state == S_DISC);
  assign disconnect_host_num_o = r_disc_host;
  assign session_up_o          = r_session_up;
  assign done_o                = r_done;
  assign fail_o                = r_fail;
  assign busy_o                = (r_state != S_IDLE);

endmodule

// File: tb/tb_fix_conn_manager.sv
// Directed bench for fix_conn_manager: per-cycle vector table plus timeout, late-ack and reset sequences.
module tb_fix_conn_manager;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] disc_i;
  logic       connected_i;
  logic [1:0] connected_host_addr_i;
  logic       connect_req_o;
  logic [1:0] connect_addr_o;
  logic       disconnect_o;
  logic [1:0] disconnect_host_num_o;
  logic [3:0] session_up_o;
  logic [3:0] done_o;
  logic [3:0] fail_o;
  logic       busy_o;
`ifdef FIX_CONN_STATS_EN
  logic [7:0] fail_count_o;
  logic [7:0] retry_count_o;
`endif

  fix_conn_manager #(
    .TIMEOUT_CYCLES(64),
    .MAX_RETRIES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .disc_i(disc_i),
    .connected_i(connected_i),
    .connected_host_addr_i(connected_host_addr_i),
    .connect_req_o(connect_req_o),
    .connect_addr_o(connect_addr_o),
    .disconnect_o(disconnect_o),
    .disconnect_host_num_o(disconnect_host_num_o),
    .session_up_o(session_up_o),
    .done_o(done_o),
    .fail_o(fail_o),
    .busy_o(busy_o)
`ifdef FIX_CONN_STATS_EN
    ,
    .fail_count_o(fail_count_o),
    .retry_count_o(retry_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {creq, caddr, disc, dnum, session, done, fail, busy}
  logic [18:0] w_obs;
  assign w_obs = {connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
                  session_up_o, done_o, fail_o, busy_o};

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  disc;
    logic        conn;
    logic [1:0]  caddr;
    logic [18:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] disc, input logic conn,
                              input logic [1:0] ca, input logic ecreq, input logic [1:0] eca,
                              input logic edisc, input logic [1:0] edn, input logic [3:0] es,
                              input logic [3:0] edone, input logic [3:0] efail, input logic eb);
    vec_t v;
    v.req   = req;
    v.disc  = disc;
    v.conn  = conn;
    v.caddr = ca;
    v.exp   = {ecreq, eca, edisc, edn, es, edone, efail, eb};
    return v;
  endfunction

  vec_t vecs[30];

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, failk, donecnt, aerr, creqcnt, busy6, donek;
    int pk[8];
    logic [3:0] failv, donev;

    // req, disc, conn, caddr | creq, caddr, disc, dnum, session, done, fail, busy
    vecs[0]  = mk(4'b0001, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[1]  = mk(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[2]  = mk(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    vecs[3]  = mk(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    vecs[4]  = mk(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    vecs[5]  = mk(4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    vecs[6]  = mk(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    vecs[7]  = mk(4'b1010, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
    vecs[8]  = mk(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
    vecs[9]  = mk(4'b0000, 4'b0000, 0, 0,  1, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    vecs[10] = mk(4'b0000, 4'b0000, 0, 0,  0, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    vecs[11] = mk(4'b0000, 4'b0000, 1, 1,  0, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
    vecs[12] = mk(4'b0000, 4'b0000, 0, 0,  0, 1, 0, 0, 4'b0011, 4'b0010, 4'b0000, 0);
    vecs[13] = mk(4'b0000, 4'b0000, 0, 0,  1, 3, 0, 0, 4'b0011, 4'b0000, 4'b0000, 1);
    vecs[14] = mk(4'b0000, 4'b0000, 0, 0,  0, 3, 0, 0, 4'b0011, 4'b0000, 4'b0000, 1);
    vecs[15] = mk(4'b0000, 4'b0000, 1, 3,  0, 3, 0, 0, 4'b0011, 4'b0000, 4'b0000, 1);
    vecs[16] = mk(4'b0000, 4'b0000, 0, 0,  0, 3, 0, 0, 4'b1011, 4'b1000, 4'b0000, 0);
    vecs[17] = mk(4'b0100, 4'b0001, 0, 0,  0, 3, 0, 0, 4'b1011, 4'b0000, 4'b0000, 0);
    vecs[18] = mk(4'b0000, 4'b0000, 0, 0,  0, 3, 0, 0, 4'b1011, 4'b0000, 4'b0000, 0);
    vecs[19] = mk(4'b0000, 4'b0000, 0, 0,  0, 3, 1, 0, 4'b1011, 4'b0000, 4'b0000, 1);
    vecs[20] = mk(4'b0000, 4'b0000, 0, 0,  0, 3, 0, 0, 4'b1010, 4'b0000, 4'b0000, 0);
    vecs[21] = mk(4'b0000, 4'b0000, 0, 0,  1, 2, 0, 0, 4'b1010, 4'b0000, 4'b0000, 1);
    vecs[22] = mk(4'b0000, 4'b0000, 1, 2,  0, 2, 0, 0, 4'b1010, 4'b0000, 4'b0000, 1);
    vecs[23] = mk(4'b0000, 4'b0000, 0, 0,  0, 2, 0, 0, 4'b1110, 4'b0100, 4'b0000, 0);
    vecs[24] = mk(4'b1010, 4'b1000, 0, 0,  0, 2, 0, 0, 4'b1110, 4'b0000, 4'b0000, 0);
    vecs[25] = mk(4'b0000, 4'b0000, 0, 0,  0, 2, 0, 0, 4'b1110, 4'b0000, 4'b0000, 0);
    vecs[26] = mk(4'b0000, 4'b0000, 0, 0,  0, 2, 1, 3, 4'b1110, 4'b0000, 4'b0000, 1);
    vecs[27] = mk(4'b0000, 4'b0001, 0, 0,  0, 2, 0, 3, 4'b0110, 4'b0000, 4'b0000, 0);
    vecs[28] = mk(4'b0000, 4'b0000, 0, 0,  0, 2, 0, 3, 4'b0110, 4'b0000, 4'b0000, 0);
    vecs[29] = mk(4'b0000, 4'b0000, 0, 0,  0, 2, 0, 3, 4'b0110, 4'b0000, 4'b0000, 0);

    rst = 1'b1;
    req_i = 4'b0000;
    disc_i = 4'b0000;
    connected_i = 1'b0;
    connected_host_addr_i = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(w_obs), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(w_obs), 32'(vecs[i].exp));
      req_i = vecs[i].req;
      disc_i = vecs[i].disc;
      connected_i = vecs[i].conn;
      connected_host_addr_i = vecs[i].caddr;
    end

    // Host 0 never acked: four attempts, then abandoned.
    @(negedge clk);
    req_i = 4'b0001; disc_i = 4'b0000; connected_i = 1'b0; connected_host_addr_i = 2'd0;
    np = 0; failk = -1; failv = 4'b0000; donecnt = 0; aerr = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      req_i = 4'b0000;
      if (connect_req_o) begin
        if (np < 8) pk[np] = k;
        np++;
        if (connect_addr_o != 2'd0) aerr++;
      end
      if (done_o != 4'b0000) donecnt++;
      if (fail_o != 4'b0000) begin
        failk = k;
        failv = fail_o;
      end
    end
    check("A_npulse", 32'(np), 32'd4);
    check("A_first", 32'(pk[0]), 32'd2);
    for (int i = 1; i < 4; i++) check($sformatf("A_spacing%0d", i), 32'(pk[i] - pk[i-1]), 32'd65);
    check("A_fail_val", 32'(failv), 32'b0001);
    check("A_fail_cyc", 32'(failk), 32'd262);
    check("A_addr", 32'(aerr), 32'd0);
    check("A_no_done", 32'(donecnt), 32'd0);
    check("A_session", 32'(session_up_o), 32'b0110);
    check("A_idle", 32'(busy_o), 32'd0);
`ifdef FIX_CONN_STATS_EN
    check("A_stat_fail", 32'(fail_count_o), 32'd1);
    check("A_stat_retry", 32'(retry_count_o), 32'd3);
`endif

    // Wrong-host ack ignored; matching ack on the last timeout cycle wins.
    @(negedge clk);
    req_i = 4'b0001;
    creqcnt = 0; donek = -1; donev = 4'b0000; failk = -1; busy6 = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      req_i = 4'b0000;
      if (connect_req_o) creqcnt++;
      if (done_o != 4'b0000) begin
        donek = k;
        donev = done_o;
      end
      if (fail_o != 4'b0000) failk = k;
      if (k == 6) busy6 = int'(busy_o);
      connected_i = (k == 5) || (k == 66);
      connected_host_addr_i = (k == 5) ? 2'd1 : 2'd0;
    end
    connected_i = 1'b0;
    check("B_creq_once", 32'(creqcnt), 32'd1);
    check("B_busy_after_wrong", 32'(busy6), 32'd1);
    check("B_done_val", 32'(donev), 32'b0001);
    check("B_done_cyc", 32'(donek), 32'd67);
    check("B_no_fail", 32'(failk), 32'hFFFF_FFFF);
    check("B_session", 32'(session_up_o), 32'b0111);

    // Reset mid-WAIT, then clean restart.
    @(negedge clk);
    req_i = 4'b1000;
    @(negedge clk);
    req_i = 4'b0000;
    @(negedge clk);
    check("C_connect3", 32'({connect_req_o, connect_addr_o}), 32'b111);
    @(negedge clk);
    @(negedge clk);
    check("C_in_wait", 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1 check("C_async_reset", 32'(w_obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("C_quiet%0d", k), 32'(w_obs), 32'd0);
    end
    req_i = 4'b0001;
    @(negedge clk);
    req_i = 4'b0000;
    @(negedge clk);
    check("C_restart_creq", 32'({connect_req_o, connect_addr_o, busy_o}), 32'b1001);
    @(negedge clk);
    connected_i = 1'b1;
    connected_host_addr_i = 2'd0;
    @(negedge clk);
    connected_i = 1'b0;
    check("C_restart_done", 32'({session_up_o, done_o}), 32'b0001_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
